// File: rtl/hex_score_pkg.sv
// Shared types and constants for the hex guess scorer.
// Optional repeat-digit rejection is enabled by HEX_SCORE_DUP_CHECK_EN.
package hex_score_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int CNT_W      = 3;
  localparam int SCORE_LAT  = 22;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXACT,
    S_PARTIAL,
    S_DONE
  } state_t;

  function automatic logic has_dup(
    input logic [NUM_DIGITS*DIGIT_W-1:0] w
  );
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      for (int j = i + 1; j < NUM_DIGITS; j++)
        if (w[i*DIGIT_W +: DIGIT_W] ==
            w[j*DIGIT_W +: DIGIT_W])
          r = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/hex_digit_sel.sv
// Combinational nibble select: picks digit idx out of a
// four-digit hex word (digit 0 = least significant nibble).
module hex_digit_sel
  import hex_score_pkg::*;
(
  input  logic [NUM_DIGITS*DIGIT_W-1:0] word,
  input  logic [1:0]                    idx,
  output logic [DIGIT_W-1:0]            digit
);

  assign digit = word[{idx, 2'b00} +: DIGIT_W];

endmodule

// File: rtl/hex_guess_scorer.sv
// Scores a four-digit hex guess against the hidden code, one pair per cycle.
// Define HEX_SCORE_DUP_CHECK_EN to reject guesses with repeated digits.
module hex_guess_scorer
  import hex_score_pkg::*;
#(
  parameter int MAX_TRIES = 8,
  parameter int TRY_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic [15:0]      guess,
  input  logic [15:0]      actual,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] exact_cnt,
  output logic [CNT_W-1:0] partial_cnt,
  output logic [TRY_W-1:0] tries,
  output logic             win,
  output logic             game_over,
  output logic             dup_err
);

  localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_TRIES);
  localparam logic [CNT_W-1:0] ALL_HIT = CNT_W'(NUM_DIGITS);

  state_t           state, state_nx;
  logic [15:0]      g_q, a_q;
  logic [3:0]       mg, ma;
  logic [CNT_W-1:0] ex, pa;
  logic [3:0]       idx;
  logic             dup_q;
  logic             dup_now;
  logic [1:0]       sel_i, sel_j;
  logic [3:0]       g_i, a_i, a_j;
  logic [TRY_W-1:0] tries_nx;
  logic             win_nx;

`ifdef HEX_SCORE_DUP_CHECK_EN
  assign dup_now = has_dup(guess);
`else
  assign dup_now = 1'b0;
`endif

  // EXACT walks i on idx[1:0]; PARTIAL walks i on idx[3:2], j on idx[1:0]
  assign sel_i = (state == S_EXACT) ? idx[1:0] : idx[3:2];
  assign sel_j = idx[1:0];

  hex_digit_sel u_gi (.word(g_q), .idx(sel_i), .digit(g_i));
  hex_digit_sel u_ai (.word(a_q), .idx(sel_i), .digit(a_i));
  hex_digit_sel u_aj (.word(a_q), .idx(sel_j), .digit(a_j));

  assign tries_nx = (tries == TRY_MAX) ? tries : tries + 1'b1;
  assign win_nx   = (ex == ALL_HIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (start && !game_over) state_nx = S_LOAD;
      S_LOAD:    state_nx = dup_now ? S_DONE : S_EXACT;
      S_EXACT:   if (idx == 4'd3) state_nx = S_PARTIAL;
      S_PARTIAL: if (idx == 4'd15) state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
    if (clear) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g_q <= '0; a_q <= '0;
      mg <= '0; ma <= '0;
      ex <= '0; pa <= '0;
      idx <= '0; dup_q <= 1'b0;
      busy <= 1'b0; done <= 1'b0;
      exact_cnt <= '0; partial_cnt <= '0;
      tries <= '0; win <= 1'b0;
      game_over <= 1'b0; dup_err <= 1'b0;
    end else if (clear) begin
      busy <= 1'b0; done <= 1'b0;
      exact_cnt <= '0; partial_cnt <= '0;
      tries <= '0; win <= 1'b0;
      game_over <= 1'b0; dup_err <= 1'b0;
    end else begin
      // outputs trail the FSM by one cycle
      busy <= (state != S_IDLE);
      done <= 1'b0;
      unique case (state)
        S_LOAD: begin
          g_q <= guess; a_q <= actual;
          mg <= '0; ma <= '0;
          ex <= '0; pa <= '0;
          idx <= '0; dup_q <= dup_now;
          exact_cnt <= '0; partial_cnt <= '0;
          dup_err <= 1'b0;
        end
        S_EXACT: begin
          if (g_i == a_i) begin
            ex <= ex + 1'b1;
            mg[sel_i] <= 1'b1;
            ma[sel_i] <= 1'b1;
          end
          idx <= (idx == 4'd3) ? 4'd0 : idx + 4'd1;
        end
        S_PARTIAL: begin
          if (!mg[sel_i] && !ma[sel_j] && g_i == a_j) begin
            pa <= pa + 1'b1;
            mg[sel_i] <= 1'b1;
            ma[sel_j] <= 1'b1;
          end
          idx <= idx + 4'd1;
        end
        S_DONE: begin
          done <= 1'b1;
          if (dup_q) begin
            dup_err <= 1'b1;
          end else begin
            exact_cnt <= ex;
            partial_cnt <= pa;
            tries <= tries_nx;
            win <= win | win_nx;
            game_over <= game_over | win_nx
                       | (tries_nx == TRY_MAX);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hex_guess_scorer.md
Name: hex_guess_scorer

Overview:
- Reads back the two 16-bit four-digit hex codes held by the guess/actual storage: the player guess and the hidden actual code.
- On a start pulse, scores the guess against the actual code one digit-pair per cycle.
  - exact: right digit, right position.
  - partial: right digit, wrong position; no double counting.
- Tracks attempts and raises win / game_over for the display and top-level game control.

Parameters:
- MAX_TRIES, 8, attempts allowed before game_over (1..15).
- TRY_W, 4, width of the tries counter; must hold MAX_TRIES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- start  in  1  request scoring of current guess/actual; sampled only in IDLE.
- clear  in  1  synchronous new-game: tries, win, game_over and scores to 0; FSM to IDLE.
- guess  in  16  player code; digit i = guess[4i+3:4i], i=0 is the least significant nibble.
- actual  in  16  hidden code, same digit layout.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; results valid from this cycle.
- exact_cnt  out  3  exact matches, 0..4.
- partial_cnt  out  3  partial matches, 0..4.
- tries  out  TRY_W  completed scored attempts.
- win  out  1  sticky; set when exact_cnt==4.
- game_over  out  1  sticky; set when win, or when tries reaches MAX_TRIES.
- dup_err  out  1  guess had repeated digits; only with the optional feature, else constant 0.

Behaviour:
- Reset values: every output is 0; FSM is in IDLE; internal snapshots and flags are 0.
- States: IDLE, LOAD, EXACT, PARTIAL, DONE.
- IDLE: start=1 and game_over=0 -> LOAD. start while game_over=1 is ignored.
- LOAD (1 cycle):
  - Snapshot guess and actual; later input changes have no effect.
  - Clear the 4-bit matched_g / matched_a flags and both counters.
- EXACT (4 cycles, i=0..3):
  - If g[i]==a[i]: exact+1, set matched_g[i] and matched_a[i].
- PARTIAL (16 cycles, i outer 0..3, j inner 0..3, one (i,j) per cycle):
  - Match when: !matched_g[i] && !matched_a[j] && g[i]==a[j].
  - On a match: partial+1, set matched_g[i] and matched_a[j].
  - The loop always runs the full 16 cycles, so latency is fixed.
- DONE (1 cycle):
  - Pulse done; publish exact_cnt and partial_cnt.
  - tries+1, saturating at MAX_TRIES.
  - Update win and game_over; return to IDLE.
- Latency: start sampled at edge N -> done high in the cycle following edge N+22. busy is high for 22 cycles (LOAD, EXACT, PARTIAL, DONE).
- exact_cnt and partial_cnt hold their values until the next LOAD.
- start while busy: ignored, not queued.
- clear in any state, including mid-scoring: aborts and returns to IDLE with no done pulse; clear wins over start in the same cycle.
- Reset mid-operation: immediate return to the reset values; no done pulse.
- Counter widths: exact + partial never exceeds 4.

Optional Feature:
- Macro: HEX_SCORE_DUP_CHECK_EN.
- Defined:
  - In LOAD, check the 6 digit pairs of guess for repeats.
  - On a repeat: go directly to DONE (done 2 cycles after start), dup_err=1, exact_cnt=partial_cnt=0; tries, win and game_over unchanged.
  - dup_err clears at the next LOAD or on clear.
- Not defined: dup_err is tied 0 and every guess is scored.

Decomposition:
- Package hex_score_pkg:
  - State enum.
  - NUM_DIGITS=4, DIGIT_W=4, CNT_W=3, SCORE_LAT=22.
- Sub-module hex_digit_sel: combinational nibble select, 16-bit word plus 2-bit index -> 4-bit digit. Instantiated for g[i], a[i] and a[j].

Test Plan:
- guess=16'h1234, actual=16'h1234, start -> done exactly 22 cycles later; exact=4, partial=0, win=1, game_over=1, tries=1.
- guess=16'h4321, actual=16'h1234 -> exact=0, partial=4, win=0.
- guess=16'h1122, actual=16'h1213, macro off -> exact=1, partial=2.
  - Same stimulus, macro on -> dup_err=1 at 2-cycle latency, scores 0, tries unchanged.
- MAX_TRIES=3, three scores of 16'h5678 vs 16'h1234 -> exact=0, partial=0 each; game_over=1 after the 3rd.
  - 4th start -> no busy, no done.
  - clear -> tries=0, game_over=0.
- Pulse start again at cycle 5 of busy -> ignored; exactly one done.
- Assert reset at cycle 10 of PARTIAL -> outputs 0 immediately, no done; a fresh start after release scores correctly.
